// File: rtl/clk_period_monitor_if.sv
// Slow-clock monitor bus: the clock under measurement in, period/duty/loss results out.
// master = monitor side, slave = consumer side.
interface clk_period_monitor_if #(
  parameter int CNT_W = 28
);
  logic             i_clk;
  logic             edge_o;
  logic [CNT_W-1:0] period_o;
  logic             period_valid;
  logic [CNT_W-1:0] high_time_o;
  logic             clk_lost;

  modport master (
    input  i_clk,
    output edge_o, period_o, period_valid, high_time_o, clk_lost
  );

  modport slave (
    output i_clk,
    input  edge_o, period_o, period_valid, high_time_o, clk_lost
  );
endinterface

// File: rtl/clk_period_monitor.sv
// Measures period (and optionally high time) of a slow asynchronous clock in clk50M cycles,
// and flags loss of clock. Optional high-time measurement: define DUTY_MEAS_EN.
module clk_period_monitor #(
  parameter int          CNT_W   = 28,
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic                  clk50M,
  input  logic                  rst,
  clk_period_monitor_if.master  mon
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [63:0]      TO_M1   = 64'(TIMEOUT) - 64'd1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [2:0]       sync_q, sync_d;
  logic             edge_q, edge_d;
  logic             pv_q, pv_d;
  logic             armed_q, armed_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             rise, timeout;

  always_comb begin
    sync_d   = {sync_q[1:0], mon.i_clk};
    rise     = sync_q[1] & ~sync_q[2];
    timeout  = (64'(cnt_q) == TO_M1);
    edge_d   = rise;
    pv_d     = 1'b0;
    period_d = period_q;
    armed_d  = armed_q;
    lost_d   = lost_q;
    cnt_d    = rise ? CNT_W'(1) : sat_inc(cnt_q);
    // A rise always beats a coincident timeout.
    if (rise) begin
      if (lost_q) begin
        lost_d  = 1'b0;
        armed_d = 1'b1;
      end else if (armed_q) begin
        period_d = cnt_q;
        pv_d     = 1'b1;
      end else begin
        armed_d = 1'b1;
      end
    end else if (timeout) begin
      lost_d  = 1'b1;
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      sync_q   <= '0;
      edge_q   <= 1'b0;
      pv_q     <= 1'b0;
      armed_q  <= 1'b0;
      lost_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      sync_q   <= sync_d;
      edge_q   <= edge_d;
      pv_q     <= pv_d;
      armed_q  <= armed_d;
      lost_q   <= lost_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

`ifdef DUTY_MEAS_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             fall;

  always_comb begin
    fall   = ~sync_q[1] & sync_q[2];
    hcnt_d = hcnt_q;
    high_d = high_q;
    if (rise)           hcnt_d = CNT_W'(1);
    else if (sync_q[2]) hcnt_d = sat_inc(hcnt_q);
    if (fall && armed_q) high_d = hcnt_q;
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign mon.high_time_o = high_q;
`else
  assign mon.high_time_o = '0;
`endif

  assign mon.edge_o       = edge_q;
  assign mon.period_valid = pv_q;
  assign mon.period_o     = period_q;
  assign mon.clk_lost     = lost_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor: two instances (28-bit/TIMEOUT 50, 4-bit counter) checked
// every cycle against an elapsed-time model, plus hand-computed expectations.
module tb_clk_period_monitor;

`ifdef DUTY_MEAS_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk50M = 1'b0;
  logic rstA   = 1'b1;
  logic rstB   = 1'b1;

  always #5 clk50M = ~clk50M;

  clk_period_monitor_if #(.CNT_W(28)) ifA ();
  clk_period_monitor_if #(.CNT_W(4))  ifB ();

  clk_period_monitor #(.CNT_W(28), .TIMEOUT(50)) dutA (
    .clk50M(clk50M), .rst(rstA), .mon(ifA.master)
  );
  // Timeout lies beyond what a 4-bit counter can reach, so only saturation shows.
  clk_period_monitor #(.CNT_W(4), .TIMEOUT(100)) dutB (
    .clk50M(clk50M), .rst(rstB), .mon(ifB.master)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic        ae [2], apv [2], al [2];
  logic [27:0] ap [2], ah [2];
  assign ae[0] = ifA.edge_o;   assign apv[0] = ifA.period_valid; assign al[0] = ifA.clk_lost;
  assign ap[0] = ifA.period_o; assign ah[0]  = ifA.high_time_o;
  assign ae[1] = ifB.edge_o;   assign apv[1] = ifB.period_valid; assign al[1] = ifB.clk_lost;
  assign ap[1] = 28'(ifB.period_o); assign ah[1] = 28'(ifB.high_time_o);

  // Model: sampled i_clk history, elapsed cycles since the last counted rise.
  longint cyc = 0;
  bit     mh [2][4];
  longint mref [2], mper [2], mhi [2], mhc [2];
  bit     marm [2], mlost [2], me [2], mpv [2], mvalid [2];
  longint mmax [2] = '{longint'(28'hFFFFFFF), 15};
  longint mto  [2] = '{50, 100};

  task automatic model_step(input int i, input bit x, input bit r);
    bit rise, fall, s2;
    longint el;
    if (r) begin
      for (int k = 0; k < 4; k++) mh[i][k] = 1'b0;
      me[i] = 0; mpv[i] = 0; mper[i] = 0; mhi[i] = 0; mhc[i] = 0;
      marm[i] = 0; mlost[i] = 0; mref[i] = cyc + 1; mvalid[i] = 1;
      return;
    end
    for (int k = 3; k > 0; k--) mh[i][k] = mh[i][k-1];
    mh[i][0] = x;
    rise = mh[i][2] & ~mh[i][3];
    fall = ~mh[i][2] & mh[i][3];
    s2   = mh[i][3];
    el   = cyc - mref[i];
    if (el > mmax[i]) el = mmax[i];
    me[i]  = rise;
    mpv[i] = 1'b0;
    if (fall && marm[i]) mhi[i] = mhc[i];
    if (rise) mhc[i] = 1;
    else if (s2 && mhc[i] < mmax[i]) mhc[i] = mhc[i] + 1;
    if (rise) begin
      if (mlost[i]) begin mlost[i] = 0; marm[i] = 1; end
      else if (marm[i]) begin mper[i] = el; mpv[i] = 1; end
      else marm[i] = 1;
      mref[i] = cyc;
    end else if (el == mto[i] - 1) begin
      mlost[i] = 1; marm[i] = 0;
    end
  endtask

  always @(posedge clk50M) begin
    cyc++;
    model_step(0, ifA.i_clk, rstA);
    model_step(1, ifB.i_clk, rstB);
  end

  // Per-cycle comparison and event bookkeeping for the directed pins.
  int     strobes [2]   = '{0, 0};
  longint last_edge [2] = '{0, 0};
  longint lost_gap [2]  = '{-1, -1};
  bit     prev_lost [2] = '{0, 0};
  bit     lost_seen [2] = '{0, 0};

  always @(negedge clk50M) begin
    for (int i = 0; i < 2; i++) begin
      if (mvalid[i]) begin
        logic [27:0] eper, ehi;
        eper = 28'(mper[i]);
        ehi  = DUTY ? 28'(mhi[i]) : 28'd0;
        n_cmp++;
        if ({ae[i], apv[i], ap[i], ah[i], al[i]} !== {me[i], mpv[i], eper, ehi, mlost[i]}) begin
          n_fail++;
          $display("FAIL cycle%0d dut%0d: edge=%b valid=%b period=%0d high=%0d lost=%b, want edge=%b valid=%b period=%0d high=%0d lost=%b",
                   cyc, i, ae[i], apv[i], ap[i], ah[i], al[i], me[i], mpv[i], eper, ehi, mlost[i]);
        end
        if (apv[i] === 1'b1) strobes[i]++;
        if (ae[i] === 1'b1) last_edge[i] = cyc;
        if (al[i] === 1'b1 && !prev_lost[i]) lost_gap[i] = cyc - last_edge[i];
        prev_lost[i] = (al[i] === 1'b1);
        if (al[i] === 1'b1) lost_seen[i] = 1'b1;
      end
    end
  end

  task automatic pin(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic set_clk(input int inst, input bit v);
    if (inst == 0) ifA.i_clk = v;
    else           ifB.i_clk = v;
  endtask

  task automatic hold(input int inst, input bit v, input int n);
    for (int k = 0; k < n; k++) begin
      set_clk(inst, v);
      @(negedge clk50M);
    end
  endtask

  task automatic pulses(input int inst, input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      hold(inst, 1'b1, hi);
      hold(inst, 1'b0, lo);
    end
  endtask

  task automatic clear_counts(input int inst);
    #1;
    strobes[inst]   = 0;
    lost_seen[inst] = 1'b0;
  endtask

  initial begin
    ifA.i_clk = 1'b0;
    ifB.i_clk = 1'b0;
    repeat (3) @(negedge clk50M);
    #1;
    pin("rst_A_outputs", longint'({ae[0], apv[0], ap[0], ah[0], al[0]}), 0);
    pin("rst_B_outputs", longint'({ae[1], apv[1], ap[1], ah[1], al[1]}), 0);
    rstA = 1'b0;

    // Period 10, 5 high / 5 low, five periods.
    clear_counts(0);
    @(negedge clk50M);
    pulses(0, 5, 5, 5);
    #1;
    pin("p10_strobes", strobes[0], 4);
    pin("p10_period", longint'(ap[0]), 10);
    pin("p10_high", longint'(ah[0]), DUTY ? 5 : 0);

    // Period 7, then 3 extra low cycles, then period 12.
    pulses(0, 3, 4, 5);
    #1;
    pin("p7_period", longint'(ap[0]), 7);
    pin("p7_high", longint'(ah[0]), DUTY ? 3 : 0);
    hold(0, 1'b0, 3);
    pulses(0, 6, 6, 1);
    #1;
    pin("switch_gap", longint'(ap[0]), 10);
    pulses(0, 6, 6, 2);
    #1;
    pin("p12_period", longint'(ap[0]), 12);

    // Loss of clock: held low.
    clear_counts(0);
    hold(0, 1'b0, 80);
    #1;
    pin("lost_level", longint'(al[0]), 1);
    pin("lost_gap", lost_gap[0], 49);
    pin("lost_no_strobe", strobes[0], 0);
    pin("lost_period_held", longint'(ap[0]), 12);
    pulses(0, 5, 5, 1);
    #1;
    pin("recover_clear", longint'(al[0]), 0);
    pin("recover_no_strobe", strobes[0], 0);
    pulses(0, 5, 5, 1);
    #1;
    pin("recover_period", longint'(ap[0]), 10);
    pin("recover_strobes", strobes[0], 1);

    // Period 49: each rise lands where the count equals TIMEOUT-1.
    clear_counts(0);
    pulses(0, 24, 25, 3);
    #1;
    pin("edge_timeout_period", longint'(ap[0]), 49);
    pin("edge_timeout_no_lost", longint'(lost_seen[0]), 0);

    // Reset pulse mid-period (low phase), then resume period 10.
    pulses(0, 5, 5, 2);
    hold(0, 1'b1, 5);
    hold(0, 1'b0, 2);
    rstA = 1'b1;
    hold(0, 1'b0, 1);
    rstA = 1'b0;
    #1;
    pin("rst_mid_clear", longint'({ae[0], apv[0], ap[0], ah[0], al[0]}), 0);
    hold(0, 1'b0, 2);
    clear_counts(0);
    pulses(0, 5, 5, 1);
    #1;
    pin("post_rst_first_rise", strobes[0], 0);
    pin("post_rst_period0", longint'(ap[0]), 0);
    pulses(0, 5, 5, 1);
    #1;
    pin("post_rst_period", longint'(ap[0]), 10);

    // 4-bit counter, period 20: saturation at 15, no wrap.
    rstB = 1'b0;
    clear_counts(1);
    @(negedge clk50M);
    pulses(1, 10, 10, 5);
    #1;
    pin("sat_period", longint'(ap[1]), 15);
    pin("sat_strobes", strobes[1], 4);
    pin("sat_no_lost", longint'(lost_seen[1]), 0);
    pin("sat_high", longint'(ah[1]), DUTY ? 10 : 0);

    hold(1, 1'b0, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
